pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register for inter-stage boundaries (D/E, E/M, M/W) of the pipelined CPU.
- Replaces a bare enable-gated register with a 2-entry skid buffer that has valid/ready flow control, flush (bubble insertion) and a registered ready.
- `in_ready` has no combinational path from `out_ready`, so stall chains across stages do not create long timing paths.
- A stage payload is any packed bundle (Instr, ALU result, write data, PC, flags) concatenated to DATA_W bits.

Parameters:
- DATA_W, 129, payload width in bits (E/M bundle: 4x32 + 1).
- RESET_DATA, 0, value loaded into both payload registers on reset/flush (0 = nop instruction word).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries; inserts a bubble.
- in_valid  input  1  upstream presents a payload.
- in_ready  output  1  stage can accept a payload this cycle; registered.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage presents a payload downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload presented downstream; driven from the main register.
- stall_cnt  output  16  saturating stall counter (see Optional Feature).

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives `out_data`) and skid register.
- States: EMPTY (none held), BUSY (main held), FULL (main and skid held).
- `out_valid` = (state != EMPTY).
- `in_ready` is a flop: 1 when the next state is not FULL.
- Reset, highest priority: state=EMPTY, main=skid=RESET_DATA, in_ready=1, out_valid=0, out_data=RESET_DATA, stall_cnt=0.
- Flush, next priority: state=EMPTY, main=skid=RESET_DATA, in_ready=1.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as delivered downstream.
- Transitions:
  - EMPTY & in_fire -> BUSY; main <= in_data.
  - BUSY & in_fire & out_fire -> BUSY; main <= in_data.
  - BUSY & in_fire & !out_ready -> FULL; skid <= in_data; in_ready drops next cycle.
  - BUSY & !in_fire & out_fire -> EMPTY; main holds its stale value.
  - FULL & out_fire -> BUSY; main <= skid; in_ready rises next cycle.
  - All other cases hold state and data.
- Latency: 1 cycle from in_fire to out_valid when downstream is not stalled.
- Throughput: 1 payload per cycle sustained.
- Ordering is strict FIFO; no payload is lost or duplicated except by flush.
- `out_data` is stable while out_valid & !out_ready.
- In EMPTY, `out_data` holds the last main value; consumers must qualify with out_valid.

Optional Feature:
- Macro PIPE_STAGE_STALL_CNT_EN.
- Defined: stall_cnt increments on every cycle with in_valid & !in_ready (not counted in reset or flush cycles). It saturates at 16'hFFFF and clears on reset only.
- Not defined: stall_cnt is tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg:
  - State encoding typedef (EMPTY/BUSY/FULL).
  - Stage payload widths and field offset constants (INSTR, ALU_RESULT, WRITE_DATA, PC, COMPARE_COND) so stage builders pack and unpack consistently.
- One natural sub-module: pipe_sat_counter (16-bit saturating counter with synchronous clear), instantiated only under the macro.

Test Plan:
- Reset mid-operation: fill to FULL with 0x11 then 0x22, assert reset 1 cycle -> next cycle out_valid=0, in_ready=1, out_data=RESET_DATA; 0x11 and 0x22 are never delivered.
- Streaming: out_ready=1, send 0x01..0x08 back-to-back -> out_data 0x01..0x08 on consecutive cycles, 1-cycle latency, in_ready constant 1.
- Skid fill:
  - Send 0xA then 0xB with out_ready=0 -> state FULL, in_ready=0 the cycle after 0xB.
  - Raise out_ready -> 0xA then 0xB delivered, in_ready=1 one cycle after the first out_fire.
- Flush in FULL with simultaneous in_valid=1 (data 0xC) -> next cycle out_valid=0; 0xC is never delivered; the following payload 0xD arrives with normal 1-cycle latency.
- Random valid/ready (10k cycles, 50% density each) -> scoreboard order and count match exactly; out_data never changes while out_valid & !out_ready.
- With PIPE_STAGE_STALL_CNT_EN: hold in_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF and holds. Without the macro -> stall_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// Purpose : shared types and payload layout for the handshaked pipeline stage registers.
// Latency : n/a (types, constants and a packing helper only).
// Backpressure: n/a.
//
// Contents:
//   stage_state_t  EMPTY / BUSY / FULL occupancy of a pipe_stage_reg
//   *_W, *_LSB     E/M stage bundle field widths and bit offsets
//   pack_em()      builds an E/M payload so producers and consumers agree on the layout
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no payload held
    ST_BUSY  = 2'd1,  // main register holds a payload
    ST_FULL  = 2'd2   // main and skid registers both hold payloads
  } stage_state_t;

  localparam int INSTR_W        = 32;
  localparam int ALU_RESULT_W   = 32;
  localparam int WRITE_DATA_W   = 32;
  localparam int PC_W           = 32;
  localparam int COMPARE_COND_W = 1;

  // Field offsets within the E/M bundle, LSB first.
  localparam int COMPARE_COND_LSB = 0;
  localparam int PC_LSB           = COMPARE_COND_LSB + COMPARE_COND_W;
  localparam int WRITE_DATA_LSB   = PC_LSB + PC_W;
  localparam int ALU_RESULT_LSB   = WRITE_DATA_LSB + WRITE_DATA_W;
  localparam int INSTR_LSB        = ALU_RESULT_LSB + ALU_RESULT_W;
  localparam int EM_DATA_W        = INSTR_LSB + INSTR_W;  // 129

  function automatic logic [EM_DATA_W-1:0] pack_em(
    input logic [INSTR_W-1:0]        instr,
    input logic [ALU_RESULT_W-1:0]   alu_result,
    input logic [WRITE_DATA_W-1:0]   write_data,
    input logic [PC_W-1:0]           pc,
    input logic [COMPARE_COND_W-1:0] compare_cond
  );
    logic [EM_DATA_W-1:0] bundle;
    bundle = '0;
    bundle[INSTR_LSB        +: INSTR_W]        = instr;
    bundle[ALU_RESULT_LSB   +: ALU_RESULT_W]   = alu_result;
    bundle[WRITE_DATA_LSB   +: WRITE_DATA_W]   = write_data;
    bundle[PC_LSB           +: PC_W]           = pc;
    bundle[COMPARE_COND_LSB +: COMPARE_COND_W] = compare_cond;
    return bundle;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Purpose : W-bit up counter that sticks at all-ones, with synchronous clear.
// Latency : count reflects an increment one cycle after inc.
// Backpressure: none; inc is sampled every cycle.
//
// Ports:
//   clk    rising-edge clock
//   clear  synchronous clear, wins over inc
//   inc    increment request for this cycle
//   count  current count value
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Purpose : valid/ready pipeline stage register built as a 2-entry skid buffer with flush.
// Latency : 1 cycle from in_fire to out_valid; 1 payload/cycle sustained.
// Backpressure: in_ready is a flop, so out_ready never reaches in_ready combinationally;
//               the skid entry absorbs the one payload accepted while ready was still high.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 squash all held payloads (bubble); an in_fire this cycle is dropped
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (out_data = main register)
//   stall_cnt             cycles with in_valid & !in_ready, saturating; only counts when
//                         PIPE_STAGE_STALL_CNT_EN is defined, otherwise tied to 0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = EM_DATA_W,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt
);

  stage_state_t      state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // in_ready_q is written alongside every state change so it always equals
  // (state != FULL) one cycle later, without depending on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state      <= ST_EMPTY;
      main_q     <= RESET_DATA;
      skid_q     <= RESET_DATA;
      in_ready_q <= 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            // Downstream stalled: park the new payload behind main.
            skid_q     <= in_data;
            state      <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            // main keeps its stale value; out_valid qualifies it.
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready_q is low here, so no in_fire can arrive.
          if (out_fire) begin
            main_q     <= skid_q;
            state      <= ST_BUSY;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic stall_inc;

  // Reset clears the counter; flush cycles are simply not counted.
  assign stall_inc = in_valid & ~in_ready_q & ~flush;

  pipe_sat_counter #(
    .W (16)
  ) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose : randomized + directed bench for pipe_stage_reg with a queue-based scoreboard.
// Latency : n/a.
// Backpressure: bench drives out_ready directly.
//
// The model treats the stage as a FIFO of capacity 2: in_ready is "fewer than two
// held", out_valid is "anything held", out_data is the oldest held payload (or the
// last one presented / RESET_DATA when nothing is held).
module tb_pipe_stage_reg;

  localparam int W = 129;
  localparam logic [W-1:0] RST_DATA = '0;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [15:0]   stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard / model state.
  logic [W-1:0] sb_q[$];
  logic [W-1:0] last_main = RST_DATA;
  int           stall_exp = 0;
  bit           chk_en = 1'b0;

  pipe_stage_reg #(
    .DATA_W     (W),
    .RESET_DATA (RST_DATA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs are stable at negedge and outputs reflect the current cycle.
  always @(negedge clk) begin
    int  sz;
    bit  exp_rdy;
    bit  exp_vld;
    bit  i_fire;
    bit  o_fire;
    logic [W-1:0] exp_dat;
    sz      = sb_q.size();
    exp_rdy = (sz < 2);
    exp_vld = (sz > 0);
    exp_dat = exp_vld ? sb_q[0] : last_main;
    if (reset) begin
      sb_q.delete();
      last_main = RST_DATA;
      stall_exp = 0;
      chk_en    = 1'b1;
    end else if (chk_en) begin
      check("out_valid", W'(out_valid), W'(exp_vld));
      check("in_ready",  W'(in_ready),  W'(exp_rdy));
      check("out_data",  out_data,      exp_dat);
`ifdef PIPE_STAGE_STALL_CNT_EN
      check("stall_cnt", W'(stall_cnt), W'(stall_exp));
`else
      check("stall_cnt", W'(stall_cnt), W'(0));
`endif
      i_fire = in_valid && exp_rdy;
      o_fire = exp_vld && out_ready;
      if (!flush && in_valid && !exp_rdy && stall_exp < 16'hFFFF) stall_exp++;
      if (o_fire) void'(sb_q.pop_front());
      if (flush) begin
        sb_q.delete();
        last_main = RST_DATA;
      end else begin
        if (i_fire) sb_q.push_back(in_data);
        if (sb_q.size() > 0) last_main = sb_q[0];
      end
    end
  end

  task automatic drive(input bit rs, input bit fl, input bit iv, input logic [W-1:0] d, input bit ordy);
    reset     = rs;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_data();
    return {$urandom_range(1, 0) == 1, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    drive(1, 0, 0, '0, 0);
    drive(1, 0, 0, '0, 0);

    // Reset mid-operation: fill to FULL with 0x11, 0x22 then reset.
    drive(0, 0, 1, W'(8'h11), 0);
    drive(0, 0, 1, W'(8'h22), 0);
    drive(0, 0, 0, '0, 0);
    drive(1, 0, 0, '0, 0);
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    // Streaming 0x01..0x08 with downstream always ready.
    for (int i = 1; i <= 8; i++) drive(0, 0, 1, W'(i), 1);
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    // Skid fill with 0xA, 0xB, then drain.
    drive(0, 0, 1, W'(8'h0A), 0);
    drive(0, 0, 1, W'(8'h0B), 0);
    drive(0, 0, 1, W'(8'hEE), 0);   // refused: stage is full
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    // Flush while FULL with a simultaneous offer of 0xC; then 0xD.
    drive(0, 0, 1, W'(8'hA1), 0);
    drive(0, 0, 1, W'(8'hB1), 0);
    drive(0, 1, 1, W'(8'h0C), 0);
    drive(0, 0, 1, W'(8'h0D), 1);
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    // Flush in BUSY with simultaneous out_fire.
    drive(0, 0, 1, W'(8'h5A), 1);
    drive(0, 1, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    // Random valid/ready, 50% each, occasional flush.
    for (int i = 0; i < 10000; i++) begin
      drive(0, ($urandom_range(199, 0) == 0), $urandom_range(1, 0) == 1,
            rand_data(), $urandom_range(1, 0) == 1);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, '0, 1);

`ifdef PIPE_STAGE_STALL_CNT_EN
    for (int i = 0; i < 70000; i++) drive(0, 0, 1, rand_data(), 0);
    check("stall_cnt_sat", W'(stall_cnt), W'(16'hFFFF));
    drive(0, 0, 1, rand_data(), 0);
    check("stall_cnt_hold", W'(stall_cnt), W'(16'hFFFF));
`else
    for (int i = 0; i < 300; i++) drive(0, 0, 1, rand_data(), 0);
`endif
    // Reset clears the counter and empties the stage.
    drive(1, 0, 0, '0, 0);
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
